// File: rtl/ps2_frame_rx_pkg.sv
// Shared PS/2 definitions: receiver FSM encodings, frame geometry, default timeout
// and the keyboard command bytes used further downstream by ps2_keyboard.
package ps2_frame_rx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } rx_state_t;

    // start + 8 data + parity + stop
    localparam int PS2_FRAME_BITS      = 11;
    localparam int DEFAULT_TIMEOUT_CYC = 60000;

    typedef enum logic [7:0] {
        KBD_CMD_SET_LEDS = 8'hED,
        KBD_CMD_ECHO     = 8'hEE,
        KBD_CMD_SCANSET  = 8'hF0,
        KBD_CMD_SET_RATE = 8'hF3,
        KBD_CMD_ENABLE   = 8'hF4,
        KBD_CMD_DISABLE  = 8'hF5,
        KBD_CMD_RESEND   = 8'hFE,
        KBD_CMD_RESET    = 8'hFF
    } kbd_cmd_t;

endpackage

// File: rtl/ps2_filter.sv
// One PS/2 line: 2-flop synchroniser followed by a run-length glitch filter that
// also emits a one-cycle falling-edge strobe of the filtered level.
module ps2_filter #(
    parameter int FILTER_LEN = 4
) (
    input  logic iClk,
    input  logic iRst,
    input  logic iPin,
    output logic oLevel,
    output logic oFall
);

    localparam int CW = (FILTER_LEN < 2) ? 1 : $clog2(FILTER_LEN + 1);

    logic          sync_p0;
    logic          sync_p1;
    logic [CW-1:0] run_cnt;

    // sync_p0 -> sync_p1 -> filtered level
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            sync_p0 <= 1'b1;
            sync_p1 <= 1'b1;
            run_cnt <= '0;
            oLevel  <= 1'b1;
            oFall   <= 1'b0;
        end else begin
            sync_p0 <= iPin;
            sync_p1 <= sync_p0;
            oFall   <= 1'b0;
            if (sync_p1 == oLevel) begin
                run_cnt <= '0;
            end else if (run_cnt == CW'(FILTER_LEN - 1)) begin
                // this sample completes a run of FILTER_LEN differing samples
                run_cnt <= '0;
                oLevel  <= sync_p1;
                oFall   <= oLevel;
            end else begin
                run_cnt <= run_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/ps2_frame_rx.sv
// PS/2 device-to-host frame receiver with first-word-fall-through scancode FIFO.
// Optional mid-frame watchdog enabled by defining PS2_RX_TIMEOUT_EN.
module ps2_frame_rx
    import ps2_frame_rx_pkg::*;
#(
    parameter int FILTER_LEN  = 4,
    parameter int FIFO_DEPTH  = 8,
    parameter int TIMEOUT_CYC = DEFAULT_TIMEOUT_CYC
) (
    input  logic       iClk,
    input  logic       iRst,
    input  logic       iPs2Clk,
    input  logic       iPs2Dat,
    input  logic       iPop,
    input  logic       iClrErr,
    output logic [7:0] oData,
    output logic       oValid,
    output logic [4:0] oCount,
    output logic       oOverflow,
    output logic       oFrameErr
);

    localparam int AW        = $clog2(FIFO_DEPTH);
    localparam int DATA_BITS = PS2_FRAME_BITS - 3;

    function automatic logic frame_good(input logic [DATA_BITS-1:0] d,
                                        input logic par_bit,
                                        input logic stop_bit);
        return (^{d, par_bit}) & stop_bit;
    endfunction

    logic clk_fall;
    logic dat_level;
    logic unused_clk_level;
    logic unused_dat_fall;

    ps2_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filter (
        .iClk   (iClk),
        .iRst   (iRst),
        .iPin   (iPs2Clk),
        .oLevel (unused_clk_level),
        .oFall  (clk_fall)
    );

    ps2_filter #(.FILTER_LEN(FILTER_LEN)) u_dat_filter (
        .iClk   (iClk),
        .iRst   (iRst),
        .iPin   (iPs2Dat),
        .oLevel (dat_level),
        .oFall  (unused_dat_fall)
    );

    rx_state_t                state;
    logic [2:0]               bitcnt;
    logic [DATA_BITS-1:0]     shreg;
    logic                     par;
    logic                     push_req;

    logic [DATA_BITS-1:0]     mem [FIFO_DEPTH];
    logic [AW-1:0]            rd_ptr;
    logic [AW-1:0]            wr_ptr;
    logic [4:0]               count;
    logic                     do_pop;
    logic                     full;
    logic                     push_ok;

`ifdef PS2_RX_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    logic [TW-1:0] tcnt;
`else
    logic unused_timeout_cyc;
    assign unused_timeout_cyc = ^TIMEOUT_CYC;
`endif

    // frame FSM: push/error flags land in the cycle after the stop-bit fall
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            state     <= ST_IDLE;
            bitcnt    <= '0;
            push_req  <= 1'b0;
            oFrameErr <= 1'b0;
`ifdef PS2_RX_TIMEOUT_EN
            tcnt      <= '0;
`endif
        end else begin
            push_req  <= 1'b0;
            oFrameErr <= 1'b0;
            if (clk_fall) begin
`ifdef PS2_RX_TIMEOUT_EN
                tcnt <= '0;
`endif
                case (state)
                    ST_IDLE: begin
                        if (!dat_level) begin
                            state  <= ST_DATA;
                            bitcnt <= '0;
                        end
                    end
                    ST_DATA: begin
                        if (bitcnt == 3'(DATA_BITS - 1)) begin
                            state <= ST_PARITY;
                        end else begin
                            bitcnt <= bitcnt + 1'b1;
                        end
                    end
                    ST_PARITY: begin
                        state <= ST_STOP;
                    end
                    ST_STOP: begin
                        state <= ST_IDLE;
                        if (frame_good(shreg, par, dat_level)) begin
                            push_req <= 1'b1;
                        end else begin
                            oFrameErr <= 1'b1;
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
`ifdef PS2_RX_TIMEOUT_EN
            else if (state == ST_IDLE) begin
                tcnt <= '0;
            end else if (tcnt == TW'(TIMEOUT_CYC - 1)) begin
                // a stalled partial frame (e.g. hot-plug) is abandoned
                state     <= ST_IDLE;
                oFrameErr <= 1'b1;
                tcnt      <= '0;
            end else begin
                tcnt <= tcnt + 1'b1;
            end
`endif
        end
    end

    assign do_pop  = iPop && (count != 5'd0);
    assign full    = (count == 5'(FIFO_DEPTH));
    assign push_ok = push_req && (!full || do_pop);

    // datapath: shift register, parity latch and FIFO storage carry no reset
    always_ff @(posedge iClk) begin
        if (clk_fall && state == ST_DATA) begin
            shreg[bitcnt] <= dat_level;
        end
        if (clk_fall && state == ST_PARITY) begin
            par <= dat_level;
        end
        if (push_ok) begin
            mem[wr_ptr] <= shreg;
        end
    end

    // FIFO control
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            count     <= '0;
            oOverflow <= 1'b0;
        end else begin
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            case ({push_ok, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            // overflow set takes priority over a same-cycle clear
            if (push_req && full && !do_pop) begin
                oOverflow <= 1'b1;
            end else if (iClrErr) begin
                oOverflow <= 1'b0;
            end
        end
    end

    assign oValid = (count != 5'd0);
    assign oCount = count;
    assign oData  = oValid ? mem[rd_ptr] : 8'h00;

endmodule
